// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_skid_reg
//  Description : Pipeline stage register with a valid/ready handshake and a
//                2-entry skid buffer (main + skid). The stage runs at one
//                transfer per cycle with one cycle of latency. in_ready and
//                out_valid are decoded from registered state only, so
//                back-pressure never forms a combinational chain between
//                stages. A synchronous flush empties the stage.
//                Optional macro PIPE_SKID_STAT_EN adds a saturating counter
//                of back-pressure cycles on stall_cnt. Without the macro
//                stall_cnt is tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_reg #(
    parameter int WIDTH    = 32,
    parameter int CLR_DATA = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    // The state encoding equals the number of entries held.
    localparam logic [1:0] c_EMPTY = 2'd0;
    localparam logic [1:0] c_BUSY  = 2'd1;
    localparam logic [1:0] c_FULL  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_load_main;
    logic             w_main_from_skid;
    logic             w_load_skid;

    // Handshake outputs depend on state only.
    assign out_valid = (r_state != c_EMPTY);
    assign in_ready  = (r_state != c_FULL);
    assign out_data  = r_main;
    assign occupancy = r_state;

    // Next-state and register load decode. Flush overrides all handshakes.
    always_comb begin
        w_in_fire        = in_valid & in_ready;
        w_out_fire       = out_valid & out_ready;
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_state_nxt = c_EMPTY;
        end else begin
            case (r_state)
                c_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt = c_BUSY;
                        w_load_main = 1'b1;
                    end
                end
                c_BUSY: begin
                    if (w_in_fire && w_out_fire) begin
                        w_load_main = 1'b1;
                    end else if (w_in_fire) begin
                        w_state_nxt = c_FULL;
                        w_load_skid = 1'b1;
                    end else if (w_out_fire) begin
                        w_state_nxt = c_EMPTY;
                    end
                end
                c_FULL: begin
                    // in_ready is low here, so only the drain side can move.
                    if (w_out_fire) begin
                        w_state_nxt      = c_BUSY;
                        w_load_main      = 1'b1;
                        w_main_from_skid = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = c_EMPTY;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Payload registers; flush zeroes them only when CLR_DATA is set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main <= '0;
            r_skid <= '0;
        end else if (flush) begin
            if (CLR_DATA != 0) begin
                r_main <= '0;
                r_skid <= '0;
            end
        end else begin
            if (w_load_main) begin
                r_main <= w_main_from_skid ? r_skid : in_data;
            end
            if (w_load_skid) begin
                r_skid <= in_data;
            end
        end
    end

`ifdef PIPE_SKID_STAT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    // Saturating count of cycles where downstream withholds ready; only rst clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && !flush && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_skid_reg
//  Description : Self-checking bench for pipe_skid_reg. Instance u_dut
//                (CLR_DATA=1, CNT_W=4) is checked with a data scoreboard plus
//                directed state checks; instance u_dut_hold (CLR_DATA=0)
//                covers flush with payload retention. Stall count expectations
//                follow PIPE_SKID_STAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_reg;

`ifdef PIPE_SKID_STAT_EN
    localparam bit c_STAT_ON = 1'b1;
`else
    localparam bit c_STAT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        a_flush = 1'b0;
    logic        a_in_valid = 1'b0;
    logic        a_in_ready;
    logic [31:0] a_in_data = '0;
    logic        a_out_valid;
    logic        a_out_ready = 1'b0;
    logic [31:0] a_out_data;
    logic [1:0]  a_occ;
    logic [3:0]  a_stall;

    logic        b_flush = 1'b0;
    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [7:0]  b_in_data = '0;
    logic        b_out_valid;
    logic        b_out_ready = 1'b0;
    logic [7:0]  b_out_data;
    logic [1:0]  b_occ;
    logic [3:0]  b_stall;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    pipe_skid_reg #(.WIDTH(32), .CLR_DATA(1), .CNT_W(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (a_flush),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .occupancy (a_occ),
        .stall_cnt (a_stall)
    );

    pipe_skid_reg #(.WIDTH(8), .CLR_DATA(0), .CNT_W(4)) u_dut_hold (
        .clk       (clk),
        .rst       (rst),
        .flush     (b_flush),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .occupancy (b_occ),
        .stall_cnt (b_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: scoreboard bookkeeping at the falling edge, then return 1 after the rising edge.
    task automatic cyc();
        logic [31:0] exp;
        @(negedge clk);
        if (a_out_valid && a_out_ready) begin
            chk("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                exp = sb_q.pop_front();
                chk("sb_data", a_out_data, exp);
            end
        end
        if (a_in_valid && a_in_ready && !a_flush)
            sb_q.push_back(a_in_data);
        if (a_flush)
            sb_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset asserted mid-cycle takes effect immediately.
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_in_ready", 32'(a_in_ready), 32'd1);
        chk("rst_out_data", a_out_data, 32'd0);
        chk("rst_occ", 32'(a_occ), 32'd0);
        chk("rst_stall", 32'(a_stall), 32'd0);
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        chk("idle_occ", 32'(a_occ), 32'd0);
        chk("idle_in_ready", 32'(a_in_ready), 32'd1);

        // Streaming 1..8 at full rate.
        a_out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 32'(i);
            cyc();
            chk("stream_occ", 32'(a_occ), 32'd1);
            chk("stream_valid", 32'(a_out_valid), 32'd1);
            chk("stream_latency", a_out_data, 32'(i));
        end
        a_in_valid = 1'b0;
        cyc();
        chk("stream_drained", 32'(a_occ), 32'd0);
        chk("stream_sb_empty", 32'(sb_q.size()), 32'd0);

        // Back-pressure: A accepted, B into skid, C held upstream.
        a_in_valid = 1'b1; a_in_data = 32'hA; a_out_ready = 1'b1;
        cyc();
        a_in_data = 32'hB; a_out_ready = 1'b0;
        cyc();
        chk("bp_occ_full", 32'(a_occ), 32'd2);
        chk("bp_in_ready", 32'(a_in_ready), 32'd0);
        a_in_data = 32'hC;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("bp_hold_data", a_out_data, 32'hA);
            chk("bp_hold_occ", 32'(a_occ), 32'd2);
        end
        chk("bp_stall_cnt", 32'(a_stall), c_STAT_ON ? 32'd5 : 32'd0);
        a_out_ready = 1'b1;
        cyc();
        chk("bp_release_data", a_out_data, 32'hB);
        chk("bp_release_occ", 32'(a_occ), 32'd1);
        cyc();
        chk("bp_c_data", a_out_data, 32'hC);
        a_in_valid = 1'b0;
        cyc();
        chk("bp_drained", 32'(a_occ), 32'd0);
        chk("bp_sb_empty", 32'(sb_q.size()), 32'd0);

        // Flush while FULL clears state and payload.
        a_in_valid = 1'b1; a_in_data = 32'h11; a_out_ready = 1'b0;
        cyc();
        a_in_data = 32'h22;
        cyc();
        chk("ff_occ_full", 32'(a_occ), 32'd2);
        a_in_data = 32'h33; a_flush = 1'b1;
        cyc();
        a_flush = 1'b0; a_in_valid = 1'b0;
        chk("ff_out_valid", 32'(a_out_valid), 32'd0);
        chk("ff_occ", 32'(a_occ), 32'd0);
        chk("ff_out_data", a_out_data, 32'd0);
        chk("ff_in_ready", 32'(a_in_ready), 32'd1);
        chk("ff_stall_kept", 32'(a_stall), c_STAT_ON ? 32'd6 : 32'd0);
        cyc();
        chk("ff_no_ghost", 32'(a_out_valid), 32'd0);

        // Flush while BUSY with in_ready=1: offered word dropped, drained word delivered.
        a_in_valid = 1'b1; a_in_data = 32'h44; a_out_ready = 1'b0;
        cyc();
        a_in_data = 32'h77; a_out_ready = 1'b1; a_flush = 1'b1;
        cyc();
        a_flush = 1'b0; a_in_valid = 1'b0;
        chk("fb_out_valid", 32'(a_out_valid), 32'd0);
        chk("fb_occ", 32'(a_occ), 32'd0);
        cyc();
        chk("fb_no_ghost", 32'(a_out_valid), 32'd0);

        // Saturation: 20 stalled cycles.
        a_in_valid = 1'b1; a_in_data = 32'h99; a_out_ready = 1'b0;
        cyc();
        a_in_valid = 1'b0;
        for (int i = 0; i < 20; i++) cyc();
        chk("sat_stall", 32'(a_stall), c_STAT_ON ? 32'd15 : 32'd0);
        chk("sat_hold_data", a_out_data, 32'h99);
        chk("sat_hold_valid", 32'(a_out_valid), 32'd1);
        a_out_ready = 1'b1;
        cyc();
        chk("sat_drained", 32'(a_occ), 32'd0);

        // Reset in the middle of a transfer.
        a_in_valid = 1'b1; a_in_data = 32'hAB; a_out_ready = 1'b0;
        cyc();
        a_in_valid = 1'b0;
        chk("mr_busy", 32'(a_occ), 32'd1);
        #2 rst = 1'b1;
        #1;
        sb_q.delete();
        chk("mr_out_valid", 32'(a_out_valid), 32'd0);
        chk("mr_in_ready", 32'(a_in_ready), 32'd1);
        chk("mr_out_data", a_out_data, 32'd0);
        chk("mr_occ", 32'(a_occ), 32'd0);
        chk("mr_stall", 32'(a_stall), 32'd0);
        cyc();
        rst = 1'b0;
        cyc();

        // CLR_DATA=0: flush drops valid state but keeps the payload.
        b_in_valid = 1'b1; b_in_data = 8'h55; b_out_ready = 1'b0;
        cyc();
        chk("hold_loaded_valid", 32'(b_out_valid), 32'd1);
        chk("hold_loaded_data", 32'(b_out_data), 32'h55);
        b_in_valid = 1'b0; b_flush = 1'b1;
        cyc();
        b_flush = 1'b0;
        chk("hold_flush_valid", 32'(b_out_valid), 32'd0);
        chk("hold_flush_data", 32'(b_out_data), 32'h55);
        chk("hold_flush_occ", 32'(b_occ), 32'd0);
        chk("hold_flush_ready", 32'(b_in_ready), 32'd1);
        b_in_valid = 1'b1; b_in_data = 8'h66;
        cyc();
        b_in_valid = 1'b0;
        chk("hold_next_valid", 32'(b_out_valid), 32'd1);
        chk("hold_next_data", 32'(b_out_data), 32'h66);
        chk("hold_next_occ", 32'(b_occ), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
Parametrised pipeline stage register with a valid/ready handshake, a 2-entry skid buffer and synchronous flush. It succeeds the plain enable/clear pipeline register, which supported only stall and flush. Sits between processor pipeline stages (e.g. IF/ID, ID/EX) so back-pressure is registered and never forms a combinational ready chain across stages. Full throughput of one transfer per cycle, one-cycle latency.

Parameters:
WIDTH, 32, payload width in bits (>=1)
CLR_DATA, 1, 1: flush and reset zero the payload registers; 0: flush clears only valid state, payload holds
CNT_W, 16, width of the stall statistics counter (used only with STAT_EN)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
flush  input  1  synchronous flush; empties the stage
in_valid  input  1  upstream payload valid
in_ready  output  1  stage can accept; registered
in_data  input  WIDTH  upstream payload
out_valid  output  1  stage holds valid payload; registered
out_ready  input  1  downstream accepts
out_data  output  WIDTH  payload, driven from main register
occupancy  output  2  entries held: 0, 1 or 2
stall_cnt  output  CNT_W  back-pressure cycle count (see Optional Feature)

Behaviour:
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (drives out_data) and skid register.
- FSM states: EMPTY (occupancy 0), BUSY (1), FULL (2).
- Decoded outputs: out_valid = (state != EMPTY); in_ready = (state != FULL). Both are functions of state only. No combinational path from any input to any output.
- EMPTY:
  - in_fire -> BUSY, main <= in_data.
  - Otherwise stay.
- BUSY:
  - in_fire & out_fire -> BUSY, main <= in_data.
  - in_fire & !out_fire -> FULL, skid <= in_data.
  - !in_fire & out_fire -> EMPTY.
  - Otherwise hold.
- FULL:
  - in_ready=0, so no input is accepted.
  - out_fire -> BUSY, main <= skid.
  - Otherwise hold.
- Ordering: strict FIFO order. No payload is duplicated or dropped, except by flush.
- Latency: data accepted in cycle N appears on out_data with out_valid=1 in cycle N+1 when the stage was EMPTY, or BUSY with out_fire.
- Data stability: while out_valid=1 and out_ready=0, out_data and out_valid hold stable.
- flush has priority over all handshake activity:
  - Next state is EMPTY.
  - A payload offered in the flush cycle is discarded even if in_ready=1.
  - An out_fire in the flush cycle still counts as delivered downstream.
  - CLR_DATA=1: main and skid <= 0. CLR_DATA=0: payload registers unchanged.
  - in_ready=1 and out_valid=0 from the next cycle.
- Reset (async, any time including mid-transfer):
  - state=EMPTY, main=skid=0 (regardless of CLR_DATA), stall_cnt=0.
  - Outputs during and after reset: out_valid=0, in_ready=1, out_data=0, occupancy=0.
- in_valid while in_ready=0 is legal: it is ignored, and upstream must hold the payload.

Optional Feature:
- Macro: PIPE_SKID_STAT_EN.
- Defined:
  - stall_cnt increments by 1 each cycle with out_valid=1 & out_ready=0 & flush=0.
  - Saturates at all-ones (no wrap).
  - Cleared only by rst; flush does not clear it.
- Not defined: stall_cnt is tied to 0 and no counter flops are synthesised.

Test Plan:
- Reset then idle: assert rst mid-cycle -> immediately out_valid=0, in_ready=1, out_data=0, occupancy=0.
- Streaming: in_valid=1 for 8 cycles with data 1..8, out_ready=1 -> out_data 1..8 on consecutive cycles starting one cycle after first accept; occupancy stays 1.
- Back-pressure: stream 0xA,0xB,0xC, out_ready=0 from cycle 2 -> occupancy reaches 2, in_ready=0, 0xC held upstream. Release out_ready -> outputs 0xA,0xB,0xC in order; stall_cnt equals stalled cycles (with STAT_EN).
- Flush when FULL with CLR_DATA=1 -> next cycle out_valid=0, occupancy=0, out_data=0. The input offered in the flush cycle never appears.
- Flush with CLR_DATA=0 when BUSY holding 0x55 -> out_valid=0 and out_data remains 0x55. The next accepted 0x66 appears normally.
- Saturation (CNT_W=4, STAT_EN): hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 15. Without the macro -> stall_cnt=0 throughout.
